// File: rtl/iter_divider_16bit.sv
// rtl/iter_divider_16bit.sv - iterative restoring unsigned divider, one quotient bit per clock
module iter_divider_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [WIDTH:0]   part_q;
    logic [WIDTH-1:0] shq_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;

    logic             accept;
    logic             last_step;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   part_n;
    logic [WIDTH-1:0] shq_n;

    // shq_q starts as the dividend and fills with quotient bits from the right
    always_comb begin
        accept    = start && (state != S_BUSY);
        last_step = (cnt_q == CW'(1));
        shifted   = {part_q, shq_q[WIDTH-1]};
        trial     = shifted - {2'b00, dvs_q};
        if (trial[WIDTH+1]) begin
            part_n = shifted[WIDTH:0];
            shq_n  = {shq_q[WIDTH-2:0], 1'b0};
        end else begin
            part_n = trial[WIDTH:0];
            shq_n  = {shq_q[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (accept) state_n = (divisor == '0) ? S_DONE : S_BUSY;
            S_BUSY: if (last_step) state_n = S_DONE;
            S_DONE: begin
                if (accept) state_n = (divisor == '0) ? S_DONE : S_BUSY;
                else        state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            part_q      <= '0;
            shq_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                dvs_q  <= divisor;
                shq_q  <= dividend;
                part_q <= '0;
                cnt_q  <= CW'(WIDTH);
                if (divisor == '0) begin
                    quotient    <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end
            end else if (state == S_BUSY) begin
                part_q <= part_n;
                shq_q  <= shq_n;
                cnt_q  <= cnt_q - CW'(1);
                if (last_step) begin
                    quotient    <= shq_n;
                    remainder   <= part_n[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

    assign busy = (state == S_BUSY);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_iter_divider_16bit.sv
// tb/tb_iter_divider_16bit.sv - directed and exhaustive checks of iter_divider_16bit
module tb_iter_divider_16bit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [15:0] quotient, remainder;

    logic        s_start = 1'b0;
    logic [3:0]  s_dividend = '0;
    logic [3:0]  s_divisor = '0;
    logic        s_busy, s_done, s_div_by_zero;
    logic [3:0]  s_quotient, s_remainder;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    iter_divider_16bit #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    iter_divider_16bit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(s_start), .dividend(s_dividend), .divisor(s_divisor),
        .busy(s_busy), .done(s_done), .quotient(s_quotient), .remainder(s_remainder),
        .div_by_zero(s_div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle or in DONE; returns at the done negedge.
    task automatic do_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input logic ez,
                          input int exp_lat);
        int lat, nbusy;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".busycyc"}, nbusy, exp_lat - 1);
        check({tag, ".q"}, quotient, eq);
        check({tag, ".r"}, remainder, er);
        check({tag, ".dbz"}, div_by_zero, ez);
    endtask

    initial begin
        int lat, seen_done;

        #1;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.q", quotient, 0);
        check("rst.r", remainder, 0);
        check("rst.dbz", div_by_zero, 0);
        start = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.start_ignored", busy | done, 0);
        start = 1'b0;
        rst = 1'b0;

        do_div("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("hold.q", quotient, 14);
        do_div("d3_10", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 17);
        do_div("dffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 17);
        do_div("dffff_ffff", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 17);
        @(negedge clk);
        do_div("d5_0", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1);
        @(negedge clk);
        do_div("d9_3", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 17);
        @(negedge clk);

        // start re-pulsed in busy cycle 4 must be ignored; operands changed mid-flight
        dividend = 16'd100; divisor = 16'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("ign.busy4", busy, 1);
        dividend = 16'd50; divisor = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 5;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("ign.lat", lat, 17);
        check("ign.q", quotient, 14);
        check("ign.r", remainder, 2);
        do_div("b2b50_5", 16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 17);
        @(negedge clk);

        // asynchronous reset mid-period in busy cycle 8
        dividend = 16'd100; divisor = 16'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("ar.busy8", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("ar.busy", busy, 0);
        check("ar.done", done, 0);
        check("ar.q", quotient, 0);
        check("ar.r", remainder, 0);
        check("ar.dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check("ar.no_done", seen_done, 0);
        do_div("ar.d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
        @(negedge clk);

        // exhaustive WIDTH=4 sweep against reference division
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                int k;
                s_dividend = 4'(a);
                s_divisor  = 4'(b);
                s_start    = 1'b1;
                @(negedge clk);
                s_start = 1'b0;
                k = 1;
                while (!s_done && k < 10) begin
                    @(negedge clk);
                    k++;
                end
                check($sformatf("w4.%0d/%0d.lat", a, b), k, (b == 0) ? 1 : 5);
                check($sformatf("w4.%0d/%0d.q", a, b), s_quotient, (b == 0) ? 15 : a / b);
                check($sformatf("w4.%0d/%0d.r", a, b), s_remainder, (b == 0) ? a : a % b);
                check($sformatf("w4.%0d/%0d.dbz", a, b), s_div_by_zero, (b == 0) ? 1 : 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
